// File: rtl/serial_div.sv
// Multi-cycle restoring divider for the EX stage. It produces one quotient bit per clock
// and returns {remainder, quotient} with a ready flag.
module serial_div #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
);

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] dvd;      // dividend magnitude, refilled with quotient bits
    logic [DATA_W-1:0] dvs;
    logic [DATA_W-1:0] rem;
    logic              signed_q;
    logic              neg1_q;
    logic              neg2_q;

    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   trial;
    logic              q_bit;
    logic [DATA_W-1:0] rem_nxt;
    logic [DATA_W-1:0] quo_nxt;
    logic [DATA_W-1:0] quo_fix;
    logic [DATA_W-1:0] rem_fix;
    logic [DATA_W-1:0] abs1;
    logic [DATA_W-1:0] abs2;

    always_comb begin
        shifted = {rem, dvd[DATA_W-1]};
        trial   = shifted - {1'b0, dvs};
        q_bit   = ~trial[DATA_W];
        rem_nxt = q_bit ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
        quo_nxt = {dvd[DATA_W-2:0], q_bit};
        // The quotient is negative when the operand signs differ. The remainder follows the dividend.
        quo_fix = (signed_q && (neg1_q ^ neg2_q)) ? (~quo_nxt + 1'b1) : quo_nxt;
        rem_fix = (signed_q && neg1_q) ? (~rem_nxt + 1'b1) : rem_nxt;
        abs1    = (signed_div_i && opdata1_i[DATA_W-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
        abs2    = (signed_div_i && opdata2_i[DATA_W-1]) ? (~opdata2_i + 1'b1) : opdata2_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FREE;
            cnt      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            rem      <= '0;
            signed_q <= 1'b0;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == '0) begin
                            state <= BYZERO;
                        end else begin
                            state    <= ON;
                            dvd      <= abs1;
                            dvs      <= abs2;
                            rem      <= '0;
                            cnt      <= '0;
                            signed_q <= signed_div_i;
                            neg1_q   <= opdata1_i[DATA_W-1];
                            neg2_q   <= opdata2_i[DATA_W-1];
                        end
                    end
                end
                BYZERO: begin
                    state    <= END;
                    result_o <= '0;
                    ready_o  <= 1'b1;
                end
                ON: begin
                    if (annul_i) begin
                        state    <= FREE;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end else begin
                        dvd <= quo_nxt;
                        rem <= rem_nxt;
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(DATA_W - 1)) begin
                            state    <= END;
                            result_o <= {rem_fix, quo_fix};
                            ready_o  <= 1'b1;
                        end
                    end
                end
                END: begin
                    if (!start_i) begin
                        state    <= FREE;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end
                end
                default: state <= FREE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_div.sv
// Directed bench for serial_div. It checks result values, latency, annul, asynchronous reset and END hold behaviour.
module tb_serial_div;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           signed_div_i;
    logic [W-1:0]   opdata1_i;
    logic [W-1:0]   opdata2_i;
    logic           start_i;
    logic           annul_i;
    logic [2*W-1:0] result_o;
    logic           ready_o;

    int n_cmp = 0;
    int n_bad = 0;

    serial_div #(.DATA_W(W), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
        .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
        .start_i(start_i), .annul_i(annul_i),
        .result_o(result_o), .ready_o(ready_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        annul_i      = 1'b0;
        start_i      = 1'b1;
    endtask

    // Edge 1 is the accepting edge. The operands are scrambled right after it, so only the sampled values should count.
    task automatic wait_ready(input string tag, input int exp_lat);
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = ~signed_div_i;
            end
        end while (!ready_o && n < 100);
        check({tag, " latency"}, 64'(n), 64'(exp_lat));
    endtask

    task automatic run_div(input string tag, input logic sgn, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [63:0] exp_res,
                           input int exp_lat, input int hold);
        launch(sgn, a, b);
        wait_ready(tag, exp_lat);
        check({tag, " result"}, result_o, exp_res);
        for (int i = 0; i < hold; i++) begin
            annul_i = 1'b1;
            @(posedge clk); #1;
            check({tag, " hold ready"}, 64'(ready_o), 64'(1));
            check({tag, " hold result"}, result_o, exp_res);
        end
        annul_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk); #1;
        check({tag, " drop ready"}, 64'(ready_o), 64'(0));
        check({tag, " drop result"}, result_o, 64'(0));
    endtask

    initial begin
        bit seen_ready;
        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;
        #1;
        check("reset ready", 64'(ready_o), 64'(0));
        check("reset result", result_o, 64'(0));
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        run_div("u100_7", 1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 33, 0);
        run_div("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'h2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 0);
        run_div("u-7_2", 1'b0, 32'hFFFF_FFF9, 32'h2, {32'h1, 32'h7FFF_FFFC}, 33, 0);
        run_div("s7_-2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD}, 33, 0);
        run_div("s-8_-3", 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, {32'hFFFF_FFFE, 32'h2}, 33, 0);
        run_div("u5_9", 1'b0, 32'd5, 32'd9, {32'h5, 32'h0}, 33, 0);
        run_div("div0", 1'b0, 32'h1234_5678, 32'h0, 64'h0, 2, 0);

        // Annul partway through the iterations. No result may ever appear.
        launch(1'b0, 32'd1000, 32'd3);
        repeat (10) begin @(posedge clk); #1; end
        check("annul pre ready", 64'(ready_o), 64'(0));
        @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk); #1;
        check("annul ready", 64'(ready_o), 64'(0));
        check("annul result", result_o, 64'(0));
        @(negedge clk) annul_i = 1'b0;
        seen_ready = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (ready_o) seen_ready = 1'b1; end
        check("annul no ready", 64'(seen_ready), 64'(0));
        run_div("post_annul", 1'b0, 32'hFFFF_FFFF, 32'h10, {32'hF, 32'h0FFF_FFFF}, 33, 0);

        // Asynchronous reset between edges, first mid-ON and then while in END.
        launch(1'b0, 32'd12345, 32'd7);
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("rst on ready", 64'(ready_o), 64'(0));
        check("rst on result", result_o, 64'(0));
        @(negedge clk);
        rst = 1'b0;
        start_i = 1'b0;
        launch(1'b0, 32'd100, 32'd7);
        wait_ready("pre_rst_end", 33);
        #2 rst = 1'b1;
        #1;
        check("rst end ready", 64'(ready_o), 64'(0));
        check("rst end result", result_o, 64'(0));
        @(negedge clk);
        rst = 1'b0;
        start_i = 1'b0;
        run_div("u9_3", 1'b0, 32'd9, 32'd3, {32'h0, 32'h3}, 33, 0);

        run_div("smin_-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
